minisrc_control_unit: RTL and testbench

Hardwired Moore control sequencer for the Mini SRC datapath. It consumes the IR contents and the CON flip-flop result, and it drives every datapath control strobe. It sequences fetch and then per-class execute steps T3..T7. It sits beside the datapath in the CPU top level and is the sole driver of the datapath's control inputs.

---
 rtl/minisrc_ctrl_pkg.sv | 76 +++++++
 rtl/minisrc_op_decode.sv | 53 +++++
 rtl/minisrc_control_unit.sv | 170 +++++++++++++++++
 tb/tb_minisrc_control_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_ctrl_pkg.sv
// Shared encodings for the Mini SRC control sequencer: opcodes, the state
// register, instruction classes and the one-hot ALU-op bit positions.
package minisrc_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Bit positions inside the one-hot ALU-op vector.
   localparam int ALU_W    = 13;
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_AND  = 2;
   localparam int ALU_OR   = 3;
   localparam int ALU_SHR  = 4;
   localparam int ALU_SHRA = 5;
   localparam int ALU_SHL  = 6;
   localparam int ALU_ROR  = 7;
   localparam int ALU_ROL  = 8;
   localparam int ALU_MUL  = 9;
   localparam int ALU_DIV  = 10;
   localparam int ALU_NEG  = 11;
   localparam int ALU_NOT  = 12;

   typedef enum logic [3:0] {
      ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3,
      ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      CLS_RTYPE, CLS_IMM, CLS_NEGNOT, CLS_MULDIV,
      CLS_LDI, CLS_LD, CLS_ST, CLS_BR,
      CLS_JR, CLS_JAL, CLS_IN, CLS_OUT,
      CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
   } cls_t;

   // Final execute step of each class; the sequencer returns to T0 after it.
   function automatic state_t last_step(input cls_t cls);
      state_t s;
      case (cls)
         CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: s = ST_T3;
         CLS_NEGNOT, CLS_JAL:                         s = ST_T4;
         CLS_RTYPE, CLS_IMM, CLS_LDI:                 s = ST_T5;
         CLS_MULDIV, CLS_ST, CLS_BR:                  s = ST_T6;
         CLS_LD:                                      s = ST_T7;
         default:                                     s = ST_T3;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/minisrc_op_decode.sv
// Combinational opcode decode: instruction class plus the ALU operation the
// class drives during its ALU step.
module minisrc_op_decode
   import minisrc_ctrl_pkg::*;
#(
   parameter logic HALT_ON_UNKNOWN = 1'b0
) (
   input  logic [4:0]       opcode_i,
   output cls_t             cls_o,
   output logic [ALU_W-1:0] alu_o
);

   // Map opcode to class and one-hot ALU op; address arithmetic uses ADD.
   always_comb begin
      cls_o = CLS_NOP;
      alu_o = '0;
      case (opcode_i)
         OP_LD:   begin cls_o = CLS_LD;     alu_o[ALU_ADD]  = 1'b1; end
         OP_LDI:  begin cls_o = CLS_LDI;    alu_o[ALU_ADD]  = 1'b1; end
         OP_ST:   begin cls_o = CLS_ST;     alu_o[ALU_ADD]  = 1'b1; end
         OP_ADD:  begin cls_o = CLS_RTYPE;  alu_o[ALU_ADD]  = 1'b1; end
         OP_SUB:  begin cls_o = CLS_RTYPE;  alu_o[ALU_SUB]  = 1'b1; end
         OP_AND:  begin cls_o = CLS_RTYPE;  alu_o[ALU_AND]  = 1'b1; end
         OP_OR:   begin cls_o = CLS_RTYPE;  alu_o[ALU_OR]   = 1'b1; end
         OP_ROR:  begin cls_o = CLS_RTYPE;  alu_o[ALU_ROR]  = 1'b1; end
         OP_ROL:  begin cls_o = CLS_RTYPE;  alu_o[ALU_ROL]  = 1'b1; end
         OP_SHR:  begin cls_o = CLS_RTYPE;  alu_o[ALU_SHR]  = 1'b1; end
         OP_SHRA: begin cls_o = CLS_RTYPE;  alu_o[ALU_SHRA] = 1'b1; end
         OP_SHL:  begin cls_o = CLS_RTYPE;  alu_o[ALU_SHL]  = 1'b1; end
         OP_ADDI: begin cls_o = CLS_IMM;    alu_o[ALU_ADD]  = 1'b1; end
         OP_ANDI: begin cls_o = CLS_IMM;    alu_o[ALU_AND]  = 1'b1; end
         OP_ORI:  begin cls_o = CLS_IMM;    alu_o[ALU_OR]   = 1'b1; end
         OP_DIV:  begin cls_o = CLS_MULDIV; alu_o[ALU_DIV]  = 1'b1; end
         OP_MUL:  begin cls_o = CLS_MULDIV; alu_o[ALU_MUL]  = 1'b1; end
         OP_NEG:  begin cls_o = CLS_NEGNOT; alu_o[ALU_NEG]  = 1'b1; end
         OP_NOT:  begin cls_o = CLS_NEGNOT; alu_o[ALU_NOT]  = 1'b1; end
         OP_BR:   begin cls_o = CLS_BR;     alu_o[ALU_ADD]  = 1'b1; end
         OP_JR:   cls_o = CLS_JR;
         OP_JAL:  cls_o = CLS_JAL;
         OP_IN:   cls_o = CLS_IN;
         OP_OUT:  cls_o = CLS_OUT;
         OP_MFHI: cls_o = CLS_MFHI;
         OP_MFLO: cls_o = CLS_MFLO;
         OP_NOP:  cls_o = CLS_NOP;
         OP_HALT: cls_o = CLS_HALT;
         default: begin
            if (HALT_ON_UNKNOWN) cls_o = CLS_HALT;
            else                 cls_o = CLS_NOP;
         end
      endcase
   end

endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0..T2, then
// per-class execute steps T3..T7, driving every datapath control strobe.
//
//   state | meaning
//   RESET | held by Clear, all strobes low
//   T0    | PC to MAR, PC+1 into Z
//   T1    | Z to PC, memory read into MDR
//   T2    | MDR to IR; opcode latched on exit
//   T3-T7 | class-specific execute steps
//   HALT  | all strobes low until Clear
module minisrc_control_unit
   import minisrc_ctrl_pkg::*;
#(
   parameter logic HALT_ON_UNKNOWN = 1'b0
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        BranchOut,
   output logic        Run,
   output logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
   output logic        InPortout, OutPortOut, Cout, BAout, Rout,
   output logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
   output logic        Rin, RAin, CONin, OutPortIn,
   output logic        Gra, Grb, Grc,
   output logic        Read, Write, IncPC,
   output logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL,
   output logic        MUL, DIV, NEG, NOT
);

   state_t           state_q, state_d;
   logic [4:0]       opcode_q;
   logic [4:0]       op_sel;
   cls_t             cls;
   logic [ALU_W-1:0] alu_vec;
   logic             alu_en;
   logic             unused_ir;

   assign unused_ir = ^IR[26:0];

   // In T2 the raw IR opcode decides nop/halt/execute; afterwards only the
   // latched copy is used, so later IR changes cannot disturb execution.
   assign op_sel = (state_q == ST_T2) ? IR[31:27] : opcode_q;

   minisrc_op_decode #(
      .HALT_ON_UNKNOWN(HALT_ON_UNKNOWN)
   ) u_decode (
      .opcode_i (op_sel),
      .cls_o    (cls),
      .alu_o    (alu_vec)
   );

   // State register and opcode latch; Clear aborts any step immediately.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q  <= ST_RESET;
         opcode_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_T2) opcode_q <= IR[31:27];
      end
   end

   // Next-state and strobe decode from state plus instruction class.
   always_comb begin
      state_d    = state_q;
      Run        = 1'b0;
      PCout      = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
      LOout      = 1'b0; HIout   = 1'b0; InPortout = 1'b0;
      OutPortOut = 1'b0; Cout    = 1'b0; BAout = 1'b0; Rout = 1'b0;
      PCin       = 1'b0; IRin    = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      Yin        = 1'b0; Zin     = 1'b0; LOin  = 1'b0; HIin  = 1'b0;
      Rin        = 1'b0; RAin    = 1'b0; CONin = 1'b0; OutPortIn = 1'b0;
      Gra        = 1'b0; Grb     = 1'b0; Grc   = 1'b0;
      Read       = 1'b0; Write   = 1'b0; IncPC = 1'b0;
      alu_en     = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_T0;
         ST_T0: begin
            Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            state_d = ST_T1;
         end
         ST_T1: begin
            Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            state_d = ST_T2;
         end
         ST_T2: begin
            Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            case (cls)
               CLS_NOP:  state_d = ST_T0;
               CLS_HALT: state_d = ST_HALT;
               default:  state_d = ST_T3;
            endcase
         end
         ST_HALT: state_d = ST_HALT;
         default: begin
            Run = 1'b1;
            case (cls)
               CLS_RTYPE, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                  case (state_q)
                     ST_T3: begin
                        Grb = 1'b1; Yin = 1'b1;
                        if (cls == CLS_RTYPE || cls == CLS_IMM) Rout = 1'b1;
                        else                                    BAout = 1'b1;
                     end
                     ST_T4: begin
                        Zin = 1'b1; alu_en = 1'b1;
                        if (cls == CLS_RTYPE) begin Grc = 1'b1; Rout = 1'b1; end
                        else                  Cout = 1'b1;
                     end
                     ST_T5: begin
                        Zlowout = 1'b1;
                        if (cls == CLS_LD || cls == CLS_ST) MARin = 1'b1;
                        else begin Gra = 1'b1; Rin = 1'b1; end
                     end
                     ST_T6: begin
                        if (cls == CLS_LD) begin Read = 1'b1; MDRin = 1'b1; end
                        if (cls == CLS_ST) begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
                     end
                     ST_T7: begin
                        if (cls == CLS_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     end
                     default: ;
                  endcase
               end
               CLS_NEGNOT: begin
                  if (state_q == ST_T3) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
                  if (state_q == ST_T4) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               end
               CLS_MULDIV: begin
                  if (state_q == ST_T3) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  if (state_q == ST_T4) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
                  if (state_q == ST_T5) begin Zlowout = 1'b1; LOin = 1'b1; end
                  if (state_q == ST_T6) begin Zhighout = 1'b1; HIin = 1'b1; end
               end
               CLS_BR: begin
                  if (state_q == ST_T3) begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                  if (state_q == ST_T4) begin PCout = 1'b1; Yin = 1'b1; end
                  if (state_q == ST_T5) begin Cout = 1'b1; Zin = 1'b1; alu_en = 1'b1; end
                  if (state_q == ST_T6) begin Zlowout = 1'b1; PCin = BranchOut; end
               end
               CLS_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               CLS_JAL: begin
                  if (state_q == ST_T3) begin PCout = 1'b1; RAin = 1'b1; end
                  if (state_q == ST_T4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               end
               CLS_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
               CLS_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: ;
            endcase
            if (state_q == last_step(cls)) state_d = ST_T0;
            else begin
               case (state_q)
                  ST_T3:   state_d = ST_T4;
                  ST_T4:   state_d = ST_T5;
                  ST_T5:   state_d = ST_T6;
                  ST_T6:   state_d = ST_T7;
                  default: state_d = ST_T0;
               endcase
            end
         end
      endcase
   end

   assign {NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD} =
      alu_en ? alu_vec : '0;

endmodule

// File: tb/tb_minisrc_control_unit.sv
module tb_minisrc_control_unit;

   logic        Clock = 1'b0;
   logic        Clear;
   logic [31:0] IR;
   logic        BranchOut;
   logic        Run;
   logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout;
   logic        InPortout, OutPortOut, Cout, BAout, Rout;
   logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin;
   logic        Rin, RAin, CONin, OutPortIn;
   logic        Gra, Grb, Grc, Read, Write, IncPC;
   logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;

   int checks = 0;
   int errors = 0;

   minisrc_control_unit dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut), .Run(Run),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .LOout(LOout), .HIout(HIout), .InPortout(InPortout), .OutPortOut(OutPortOut),
      .Cout(Cout), .BAout(BAout), .Rout(Rout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
      .LOin(LOin), .HIin(HIin), .Rin(Rin), .RAin(RAin), .CONin(CONin), .OutPortIn(OutPortIn),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write), .IncPC(IncPC),
      .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
      .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT)
   );

   logic [42:0] ctl;
   assign ctl = {Run, NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR, OR, AND, SUB, ADD,
                 IncPC, Write, Read, Grc, Grb, Gra, OutPortIn, CONin, RAin, Rin, HIin,
                 LOin, Zin, Yin, MDRin, MARin, IRin, PCin, Rout, BAout, Cout, OutPortOut,
                 InPortout, HIout, LOout, MDRout, Zhighout, Zlowout, PCout};

   localparam logic [42:0] Z0 = 43'd0;
   localparam logic [42:0] M_PCOUT = 43'd1 << 0,  M_ZLOWOUT = 43'd1 << 1,  M_ZHIGHOUT = 43'd1 << 2;
   localparam logic [42:0] M_MDROUT = 43'd1 << 3, M_LOOUT = 43'd1 << 4,    M_HIOUT = 43'd1 << 5;
   localparam logic [42:0] M_INPORTOUT = 43'd1 << 6, M_OUTPORTOUT = 43'd1 << 7, M_COUT = 43'd1 << 8;
   localparam logic [42:0] M_BAOUT = 43'd1 << 9,  M_ROUT = 43'd1 << 10,    M_PCIN = 43'd1 << 11;
   localparam logic [42:0] M_IRIN = 43'd1 << 12,  M_MARIN = 43'd1 << 13,   M_MDRIN = 43'd1 << 14;
   localparam logic [42:0] M_YIN = 43'd1 << 15,   M_ZIN = 43'd1 << 16,     M_LOIN = 43'd1 << 17;
   localparam logic [42:0] M_HIIN = 43'd1 << 18,  M_RIN = 43'd1 << 19,     M_RAIN = 43'd1 << 20;
   localparam logic [42:0] M_CONIN = 43'd1 << 21, M_OUTPORTIN = 43'd1 << 22, M_GRA = 43'd1 << 23;
   localparam logic [42:0] M_GRB = 43'd1 << 24,   M_GRC = 43'd1 << 25,     M_READ = 43'd1 << 26;
   localparam logic [42:0] M_WRITE = 43'd1 << 27, M_INCPC = 43'd1 << 28,   M_ADD = 43'd1 << 29;
   localparam logic [42:0] M_SUB = 43'd1 << 30,   M_OR = 43'd1 << 32,      M_MUL = 43'd1 << 38;
   localparam logic [42:0] M_NEG = 43'd1 << 40,   M_RUN = 43'd1 << 42;

   localparam logic [42:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
   localparam logic [42:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
   localparam logic [42:0] F2 = M_MDROUT | M_IRIN | M_RUN;

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Clear = 1'b1; IR = 32'h0; BranchOut = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (ctl !== Z0) begin
            errors++;
            $display("FAIL reset cycle %0d: got %h expected %h", i, ctl, Z0);
         end
      end
      Clear = 1'b0;
      step();
      checks++;
      if (ctl !== F0) begin
         errors++;
         $display("FAIL reset_release_t0: got %h expected %h", ctl, F0);
      end
   endtask

   // Starts with T0 sampled; checks T1..T5 and the following T0.
   // The IR is replaced after the opcode latch to confirm it is ignored.
   task automatic test_add();
      logic [42:0] seq [0:5];
      seq = '{F1, F2, M_GRB | M_ROUT | M_YIN | M_RUN,
              M_GRC | M_ROUT | M_ADD | M_ZIN | M_RUN,
              M_ZLOWOUT | M_GRA | M_RIN | M_RUN, F0};
      IR = 32'h18918000;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ctl !== seq[i]) begin
            errors++;
            $display("FAIL add step %0d: got %h expected %h", i, ctl, seq[i]);
         end
         if (i == 2) IR = 32'hD8000000;
      end
   endtask

   task automatic test_ld();
      logic [42:0] seq [0:7];
      seq = '{F1, F2, M_GRB | M_BAOUT | M_YIN | M_RUN,
              M_COUT | M_ADD | M_ZIN | M_RUN,
              M_ZLOWOUT | M_MARIN | M_RUN,
              M_READ | M_MDRIN | M_RUN,
              M_MDROUT | M_GRA | M_RIN | M_RUN, F0};
      IR = 32'h01000095;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (ctl !== seq[i]) begin
            errors++;
            $display("FAIL ld step %0d: got %h expected %h", i, ctl, seq[i]);
         end
      end
   endtask

   task automatic test_br();
      logic [42:0] seq [0:6];
      IR = 32'h99800004;
      for (int b = 0; b < 2; b++) begin
         BranchOut = (b == 1);
         seq = '{F1, F2, M_GRA | M_ROUT | M_CONIN | M_RUN,
                 M_PCOUT | M_YIN | M_RUN,
                 M_COUT | M_ADD | M_ZIN | M_RUN,
                 M_ZLOWOUT | M_RUN | ((b == 1) ? M_PCIN : Z0), F0};
         for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (ctl !== seq[i]) begin
               errors++;
               $display("FAIL br(BranchOut=%0d) step %0d: got %h expected %h", b, i, ctl, seq[i]);
            end
         end
      end
      BranchOut = 1'b0;
   endtask

   task automatic test_mul();
      logic [42:0] seq [0:6];
      seq = '{F1, F2, M_GRA | M_ROUT | M_YIN | M_RUN,
              M_GRB | M_ROUT | M_MUL | M_ZIN | M_RUN,
              M_ZLOWOUT | M_LOIN | M_RUN,
              M_ZHIGHOUT | M_HIIN | M_RUN, F0};
      IR = 32'h80918000;
      for (int i = 0; i < 7; i++) begin
         step();
         checks++;
         if (ctl !== seq[i]) begin
            errors++;
            $display("FAIL mul step %0d: got %h expected %h", i, ctl, seq[i]);
         end
      end
      // Second pass aborted by Clear while in T4.
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (ctl !== seq[i]) begin
            errors++;
            $display("FAIL mul_abort step %0d: got %h expected %h", i, ctl, seq[i]);
         end
      end
      Clear = 1'b1;
      #1;
      checks++;
      if (ctl !== Z0) begin
         errors++;
         $display("FAIL mul_abort_clear: got %h expected %h", ctl, Z0);
      end
      Clear = 1'b0;
      step();
      checks++;
      if (ctl !== F0) begin
         errors++;
         $display("FAIL mul_abort_restart: got %h expected %h", ctl, F0);
      end
   endtask

   task automatic test_misc();
      logic [31:0] irs  [0:10];
      int          lens [0:10];
      logic [42:0] seqs [0:10][0:7];
      irs[0]  = 32'hA0000000; lens[0] = 4;   // jr
      seqs[0] = '{F1, F2, M_GRA | M_ROUT | M_PCIN | M_RUN, F0, Z0, Z0, Z0, Z0};
      irs[1]  = 32'hA8000000; lens[1] = 5;   // jal
      seqs[1] = '{F1, F2, M_PCOUT | M_RAIN | M_RUN, M_GRA | M_ROUT | M_PCIN | M_RUN, F0, Z0, Z0, Z0};
      irs[2]  = 32'h88000000; lens[2] = 5;   // neg
      seqs[2] = '{F1, F2, M_GRB | M_ROUT | M_NEG | M_ZIN | M_RUN, M_ZLOWOUT | M_GRA | M_RIN | M_RUN,
                  F0, Z0, Z0, Z0};
      irs[3]  = 32'h70000000; lens[3] = 6;   // ori
      seqs[3] = '{F1, F2, M_GRB | M_ROUT | M_YIN | M_RUN, M_COUT | M_OR | M_ZIN | M_RUN,
                  M_ZLOWOUT | M_GRA | M_RIN | M_RUN, F0, Z0, Z0};
      irs[4]  = 32'h10000000; lens[4] = 7;   // st
      seqs[4] = '{F1, F2, M_GRB | M_BAOUT | M_YIN | M_RUN, M_COUT | M_ADD | M_ZIN | M_RUN,
                  M_ZLOWOUT | M_MARIN | M_RUN, M_GRA | M_ROUT | M_WRITE | M_RUN, F0, Z0};
      irs[5]  = 32'hB0000000; lens[5] = 4;   // in
      seqs[5] = '{F1, F2, M_INPORTOUT | M_GRA | M_RIN | M_RUN, F0, Z0, Z0, Z0, Z0};
      irs[6]  = 32'hB8000000; lens[6] = 4;   // out
      seqs[6] = '{F1, F2, M_GRA | M_ROUT | M_OUTPORTIN | M_RUN, F0, Z0, Z0, Z0, Z0};
      irs[7]  = 32'hC0000000; lens[7] = 4;   // mfhi
      seqs[7] = '{F1, F2, M_HIOUT | M_GRA | M_RIN | M_RUN, F0, Z0, Z0, Z0, Z0};
      irs[8]  = 32'hC8000000; lens[8] = 4;   // mflo
      seqs[8] = '{F1, F2, M_LOOUT | M_GRA | M_RIN | M_RUN, F0, Z0, Z0, Z0, Z0};
      irs[9]  = 32'hD0000000; lens[9] = 3;   // nop
      seqs[9] = '{F1, F2, F0, Z0, Z0, Z0, Z0, Z0};
      irs[10] = 32'hE0000000; lens[10] = 3;  // undefined opcode runs as nop
      seqs[10] = '{F1, F2, F0, Z0, Z0, Z0, Z0, Z0};
      for (int k = 0; k < 11; k++) begin
         IR = irs[k];
         for (int i = 0; i < lens[k]; i++) begin
            step();
            checks++;
            if (ctl !== seqs[k][i]) begin
               errors++;
               $display("FAIL misc ir=%h step %0d: got %h expected %h", irs[k], i, ctl, seqs[k][i]);
            end
         end
      end
   endtask

   task automatic test_halt();
      logic [42:0] seq [0:1];
      seq = '{F1, F2};
      IR = 32'hD8000000;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (ctl !== seq[i]) begin
            errors++;
            $display("FAIL halt_fetch step %0d: got %h expected %h", i, ctl, seq[i]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (ctl !== Z0) begin
            errors++;
            $display("FAIL halt_hold cycle %0d: got %h expected %h", i, ctl, Z0);
         end
         IR = {i[4:0], 27'h0};
      end
      Clear = 1'b1;
      #2;
      checks++;
      if (ctl !== Z0) begin
         errors++;
         $display("FAIL halt_clear: got %h expected %h", ctl, Z0);
      end
      Clear = 1'b0;
      step();
      checks++;
      if (ctl !== F0) begin
         errors++;
         $display("FAIL halt_restart_t0: got %h expected %h", ctl, F0);
      end
      step();
      checks++;
      if (ctl !== F1) begin
         errors++;
         $display("FAIL halt_restart_t1: got %h expected %h", ctl, F1);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ld();
      test_br();
      test_mul();
      test_misc();
      test_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
